// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle Moore control FSM with registered outputs for a small ARM-like datapath.
// Define COND_EXEC_EN to evaluate ARM condition codes in EXEC; otherwise every instruction executes.
`timescale 1ns/1ps
module cpu_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [3:0] cond,
    input  logic       en_status,
    input  logic [3:0] status_flags,
    input  logic       mem_ready,
    output logic       load_ir,
    output logic       load_pc,
    output logic       load_ab,
    output logic       load_c,
    output logic       load_status,
    output logic       mem_en,
    output logic       mem_wr,
    output logic       reg_wen,
    output logic       halted,
    output logic [1:0] sel_pc,
    output logic [1:0] sel_wb,
    output logic [1:0] sel_wdst
);
    typedef enum logic [2:0] {
        ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_WB_BASE, ST_HALT
    } state_t;

    typedef enum logic [2:0] {CL_ALU, CL_BRANCH, CL_LOAD, CL_STORE, CL_HALT} class_t;

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       load_ab;
        logic       load_c;
        logic       load_status;
        logic       mem_en;
        logic       mem_wr;
        logic       reg_wen;
        logic       halted;
        logic [1:0] sel_pc;
        logic [1:0] sel_wb;
        logic [1:0] sel_wdst;
    } ctrl_t;

    state_t     state, state_n;
    logic [6:0] op_q, op_n;
    logic       ok_q, ok_n;
    logic       es_q, es_n;
    logic       cond_ok;
    ctrl_t      ctrl_q, ctrl_n;

    function automatic class_t op_class(input logic [6:0] op);
        if (op == 7'b0000001) return CL_HALT;
        if (!op[6]) return CL_ALU;
        case (op[6:3])
            4'b1000:                   return CL_BRANCH;
            4'b1001, 4'b1100, 4'b1101: return CL_LOAD;
            4'b1110, 4'b1111:          return CL_STORE;
            default:                   return CL_HALT;
        endcase
    endfunction

    function automatic logic is_cmp(input logic [6:0] op);
        return op[3] && (op[2:0] == 3'b010);
    endfunction

    // Base register is written back for post-indexed (P=0) or write-back (W=1) forms.
    function automatic logic base_wb(input logic [6:0] op);
        return op[0] || !op[2];
    endfunction

`ifdef COND_EXEC_EN
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cy;
            4'h3:    return !cy;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cy && !z;
            4'h9:    return !cy || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    assign cond_ok = cond_pass(cond, status_flags);
`else
    logic unused_cond;
    assign unused_cond = ^{cond, status_flags};
    assign cond_ok     = 1'b1;
`endif

    function automatic ctrl_t ctrl_of(input state_t st, input logic [6:0] op,
                                      input logic ok, input logic es);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.load_ir = 1'b1;
                c.load_pc = 1'b1;
            end
            ST_DECODE: c.load_ab = 1'b1;
            ST_EXEC: if (ok) begin
                case (op_class(op))
                    CL_ALU: begin
                        c.load_c      = 1'b1;
                        c.load_status = es | is_cmp(op);
                    end
                    CL_BRANCH: begin
                        c.load_pc = 1'b1;
                        c.sel_pc  = op[0] ? 2'b10 : 2'b01;
                    end
                    CL_LOAD, CL_STORE: c.load_c = 1'b1;
                    default: ;
                endcase
            end
            ST_MEM: begin
                c.mem_en = 1'b1;
                c.mem_wr = (op_class(op) == CL_STORE);
            end
            ST_WB: begin
                c.reg_wen = 1'b1;
                case (op_class(op))
                    CL_LOAD:   c.sel_wb = 2'b01;
                    CL_BRANCH: begin
                        c.sel_wb   = 2'b10;
                        c.sel_wdst = 2'b10;
                    end
                    default: ;
                endcase
            end
            ST_WB_BASE: begin
                c.reg_wen  = 1'b1;
                c.sel_wb   = 2'b11;
                c.sel_wdst = 2'b01;
            end
            ST_HALT: c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Outputs are registered from the next state and the instruction fields it will see.
    always_comb begin
        state_n = state;
        op_n    = op_q;
        ok_n    = ok_q;
        es_n    = es_q;
        case (state)
            ST_RESET:  state_n = ST_FETCH;
            ST_FETCH:  state_n = ST_DECODE;
            ST_DECODE: begin
                op_n    = opcode;
                ok_n    = cond_ok;
                es_n    = en_status;
                state_n = (op_class(opcode) == CL_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (!ok_q) state_n = ST_FETCH;
                else begin
                    case (op_class(op_q))
                        CL_ALU:    state_n = is_cmp(op_q) ? ST_FETCH : ST_WB;
                        CL_BRANCH: state_n = op_q[2] ? ST_WB : ST_FETCH;
                        default:   state_n = ST_MEM;
                    endcase
                end
            end
            ST_MEM: if (mem_ready) begin
                if (op_class(op_q) == CL_LOAD) state_n = ST_WB;
                else state_n = base_wb(op_q) ? ST_WB_BASE : ST_FETCH;
            end
            ST_WB: state_n = (op_class(op_q) == CL_LOAD && base_wb(op_q)) ? ST_WB_BASE : ST_FETCH;
            ST_WB_BASE: state_n = ST_FETCH;
            ST_HALT:    state_n = ST_HALT;
            default:    state_n = ST_FETCH;
        endcase
        ctrl_n = ctrl_of(state_n, op_n, ok_n, es_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RESET;
            op_q   <= '0;
            ok_q   <= 1'b0;
            es_q   <= 1'b0;
            ctrl_q <= '0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            ok_q   <= ok_n;
            es_q   <= es_n;
            ctrl_q <= ctrl_n;
        end
    end

    assign {load_ir, load_pc, load_ab, load_c, load_status, mem_en, mem_wr,
            reg_wen, halted, sel_pc, sel_wb, sel_wdst} = ctrl_q;
endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard testbench for cpu_controller: a per-instruction cycle-trace model feeds a queue
// that a negedge monitor drains; directed cases followed by randomized instructions and resets.
`timescale 1ns/1ps
module tb_cpu_controller;
    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [3:0] cond;
    logic       en_status;
    logic [3:0] status_flags;
    logic       mem_ready;
    logic       load_ir, load_pc, load_ab, load_c, load_status;
    logic       mem_en, mem_wr, reg_wen, halted;
    logic [1:0] sel_pc, sel_wb, sel_wdst;

    cpu_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond(cond), .en_status(en_status),
        .status_flags(status_flags), .mem_ready(mem_ready),
        .load_ir(load_ir), .load_pc(load_pc), .load_ab(load_ab), .load_c(load_c),
        .load_status(load_status), .mem_en(mem_en), .mem_wr(mem_wr), .reg_wen(reg_wen),
        .halted(halted), .sel_pc(sel_pc), .sel_wb(sel_wb), .sel_wdst(sel_wdst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe masks, packed as {ir,pc,ab,c,status,mem_en,mem_wr,reg_wen,halted}
    localparam logic [8:0] S_IR  = 9'b100000000;
    localparam logic [8:0] S_PC  = 9'b010000000;
    localparam logic [8:0] S_AB  = 9'b001000000;
    localparam logic [8:0] S_C   = 9'b000100000;
    localparam logic [8:0] S_ST  = 9'b000010000;
    localparam logic [8:0] S_MEN = 9'b000001000;
    localparam logic [8:0] S_MWR = 9'b000000100;
    localparam logic [8:0] S_WEN = 9'b000000010;
    localparam logic [8:0] S_HLT = 9'b000000001;

    typedef struct packed {
        logic [31:0] id;
        logic [14:0] v;
    } exp_t;

    logic [14:0] dut_v;
    assign dut_v = {load_ir, load_pc, load_ab, load_c, load_status, mem_en, mem_wr,
                    reg_wen, halted, sel_pc, sel_wb, sel_wdst};

    exp_t        exp_q[$];
    exp_t        e;
    logic [14:0] tr_vec[0:31];
    logic        tr_rdy[0:31];
    int          tr_len;
    bit          tr_halt;
    bit          mon_on;
    int          inst_id;
    int          n_checks;
    int          n_fails;

    task automatic chk(input string name, input logic [14:0] got, input logic [14:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %b required %b", name, got, want);
        end
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Condition codes come in complementary pairs: even code = base test, odd = its inverse.
    function automatic bit cond_model(input logic [3:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
`else
        bit unused_cf;
        unused_cf = ^{c, f};
        return 1'b1;
`endif
    endfunction

    task automatic add(input logic [8:0] s, input logic [1:0] spc, input logic [1:0] swb,
                       input logic [1:0] swd, input logic rdy);
        tr_vec[tr_len] = {s, spc, swb, swd};
        tr_rdy[tr_len] = rdy;
        tr_len++;
    endtask

    // Builds the expected per-cycle output trace of one instruction, starting at its fetch cycle.
    task automatic model(input logic [6:0] op, input logic [3:0] c, input logic [3:0] f,
                         input logic es, input int waits);
        bit alu, br, ld, st, cmp;
        br   = (op[6:3] == 4'b1000);
        ld   = op[6:3] inside {4'b1001, 4'b1101, 4'b1100};
        st   = op[6:3] inside {4'b1111, 4'b1110};
        tr_halt = (op == 7'b0000001) || (op[6] && !br && !ld && !st);
        alu  = !tr_halt && !op[6];
        tr_len = 0;
        add(S_IR | S_PC, 2'b00, 2'b00, 2'b00, rnd_bit());
        add(S_AB, 2'b00, 2'b00, 2'b00, rnd_bit());
        if (tr_halt) begin
            repeat (4) add(S_HLT, 2'b00, 2'b00, 2'b00, rnd_bit());
            return;
        end
        if (!cond_model(c, f)) begin
            add(9'b0, 2'b00, 2'b00, 2'b00, rnd_bit());
            return;
        end
        if (alu) begin
            cmp = op[3] && (op[2:0] == 3'b010);
            add(S_C | ((es || cmp) ? S_ST : 9'b0), 2'b00, 2'b00, 2'b00, rnd_bit());
            if (!cmp) add(S_WEN, 2'b00, 2'b00, 2'b00, rnd_bit());
        end else if (br) begin
            add(S_PC, op[0] ? 2'b10 : 2'b01, 2'b00, 2'b00, rnd_bit());
            if (op[2]) add(S_WEN, 2'b00, 2'b10, 2'b10, rnd_bit());
        end else begin
            add(S_C, 2'b00, 2'b00, 2'b00, rnd_bit());
            for (int i = 0; i <= waits; i++)
                add(S_MEN | (st ? S_MWR : 9'b0), 2'b00, 2'b00, 2'b00, i == waits);
            if (ld) add(S_WEN, 2'b00, 2'b01, 2'b00, rnd_bit());
            if (op[0] || !op[2]) add(S_WEN, 2'b00, 2'b11, 2'b01, rnd_bit());
        end
    endtask

    // Called mid-cycle just after a posedge; returns just after the edge that enters FETCH.
    task automatic do_reset();
        @(negedge clk);
        #2;
        mon_on = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        #1 chk("rst_async", dut_v, 15'b0);
        @(negedge clk);
        chk("rst_hold", dut_v, 15'b0);
        #1 rst_n = 1'b1;
        #1 chk("rst_release", dut_v, 15'b0);
        @(posedge clk);
        #1;
    endtask

    // cut >= 0 stops after that trace cycle and applies reset inside it.
    task automatic run_instr(input logic [6:0] op, input logic [3:0] c, input logic [3:0] f,
                             input logic es, input int waits, input int cut);
        int n;
        model(op, c, f, es, waits);
        if (cut >= tr_len) cut = -1;
        if (tr_halt) cut = tr_len - 1;
        n = (cut >= 0) ? cut + 1 : tr_len;
        opcode = op; cond = c; status_flags = f; en_status = es;
        for (int k = 0; k < n; k++) exp_q.push_back({inst_id[31:0], tr_vec[k]});
        mon_on = 1'b1;
        for (int k = 0; k < ((cut >= 0) ? n - 1 : n); k++) begin
            mem_ready = tr_rdy[k];
            @(posedge clk);
            #1;
        end
        if (cut >= 0) begin
            mem_ready = tr_rdy[n - 1];
            do_reset();
        end
        inst_id++;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL scoreboard_empty: got %b required a queued expectation", dut_v);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("instr%0d_cycle", e.id), dut_v, e.v);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int cut;
        n_checks = 0; n_fails = 0; inst_id = 0; mon_on = 1'b0;
        rst_n = 1'b1; opcode = '0; cond = 4'hE; en_status = 1'b0;
        status_flags = '0; mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        do_reset();

        run_instr(7'b0011000, 4'hE, 4'h0, 1'b1, 0, -1);   // ADD reg, S=1
        run_instr(7'b0001010, 4'hE, 4'h0, 1'b0, 0, -1);   // CMP
        run_instr(7'b1000000, 4'h0, 4'h0, 1'b0, 0, -1);   // BEQ, Z clear
        run_instr(7'b1000000, 4'h0, 4'h4, 1'b0, 0, -1);   // BEQ, Z set
        run_instr(7'b1101110, 4'hE, 4'h0, 1'b0, 3, -1);   // LDR imm, 3 wait cycles
        run_instr(7'b1100011, 4'hE, 4'h0, 1'b0, 1, -1);   // LDR with base write-back
        run_instr(7'b1111011, 4'hE, 4'h0, 1'b0, 0, -1);   // STR W=1
        run_instr(7'b1110110, 4'hE, 4'h0, 1'b0, 2, -1);   // STR no write-back
        run_instr(7'b1000101, 4'hE, 4'h0, 1'b0, 0, -1);   // BLX
        run_instr(7'b1000001, 4'hF, 4'h0, 1'b0, 0, -1);   // BX
        run_instr(7'b0011000, 4'h1, 4'h4, 1'b1, 0, -1);   // ADDNE with Z set
        run_instr(7'b1111000, 4'hE, 4'h0, 1'b0, 5, 4);    // reset while in MEM
        run_instr(7'b0000001, 4'hE, 4'h0, 1'b0, 0, -1);   // HALT
        run_instr(7'b1010000, 4'hE, 4'h0, 1'b0, 0, -1);   // unused class halts

        for (int i = 0; i < 250; i++) begin
            cut = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 9)) : -1;
            run_instr(7'($urandom), 4'($urandom), 4'($urandom), rnd_bit(),
                      int'($urandom_range(0, 4)), cut);
        end
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
